// File: rtl/commit_unit_pkg.sv
// Shared types for the commit stage: ROB head entry layout, itype codes and FSM states.
package commit_unit_pkg;

  localparam int unsigned CU_XLEN = 32;

  localparam logic [1:0] ITYPE_BRANCH = 2'b00;
  localparam logic [1:0] ITYPE_STORE  = 2'b01;
  localparam logic [1:0] ITYPE_ALU    = 2'b10;
  localparam logic [1:0] ITYPE_LOAD   = 2'b11;

  typedef struct packed {
    logic               ready;
    logic [1:0]         itype;
    logic [3:0]         ROB_number;
    logic [4:0]         dest_reg;
    logic [CU_XLEN-1:0] value;
    logic [CU_XLEN-1:0] store_addr;
    logic [CU_XLEN-1:0] pc;
    logic [CU_XLEN-1:0] branch_target;
    logic               branch_result;
    logic               pred_taken;
  } ROB_entry_t;

  typedef enum logic [1:0] {
    S_COMMIT  = 2'd0,
    S_ST_WAIT = 2'd1,
    S_FLUSH   = 2'd2
  } commit_state_t;

endpackage

// File: rtl/commit_branch_resolve.sv
// Combinational branch resolution: mispredict detect and corrected fetch PC.
module commit_branch_resolve #(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_target,
  input  logic            i_branch_result,
  input  logic            i_pred_taken,
  output logic            o_mispredict,
  output logic [XLEN-1:0] o_redirect_pc
);

  assign o_mispredict  = (i_branch_result != i_pred_taken);
  // Fall-through PC wraps naturally at the top of the address space.
  assign o_redirect_pc = i_branch_result ? i_target : (i_pc + XLEN'(4));

endmodule

// File: rtl/commit_unit.sv
// In-order retirement stage: register writeback, store handshake, mispredict flush/redirect.
// Optional performance counters are enabled with `define COMMIT_PERF_CNT_EN.
module commit_unit
  import commit_unit_pkg::*;
#(
  parameter int unsigned XLEN         = CU_XLEN,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  ROB_entry_t       head,
  input  logic             head_ready,
  input  logic             rob_empty,
  input  logic             rob_head_store,
  output logic             rd_en,
  output logic             rf_we,
  output logic [4:0]       rf_waddr,
  output logic [XLEN-1:0]  rf_wdata,
  output logic [3:0]       rf_wrob,
  output logic             mem_req,
  output logic [XLEN-1:0]  mem_addr,
  output logic [XLEN-1:0]  mem_wdata,
  input  logic             mem_ack,
  output logic             flush,
  output logic             redirect_valid,
  output logic [XLEN-1:0]  redirect_pc
`ifdef COMMIT_PERF_CNT_EN
  ,
  output logic [31:0]      retired_cnt,
  output logic [31:0]      mispredict_cnt
`endif
);

  localparam int unsigned CNT_W = (FLUSH_CYCLES < 1) ? 1 : $clog2(FLUSH_CYCLES + 1);

  commit_state_t    r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             w_eligible;
  logic             w_mispredict;
  logic [XLEN-1:0]  w_redirect_pc;
  logic             w_unused_ready;

  // The ROB's own ready bit is mirrored on head_ready, which is the one we act on.
  assign w_unused_ready = head.ready;

  commit_branch_resolve #(.XLEN(XLEN)) u_branch_resolve (
    .i_pc            (XLEN'(head.pc)),
    .i_target        (XLEN'(head.branch_target)),
    .i_branch_result (head.branch_result),
    .i_pred_taken    (head.pred_taken),
    .o_mispredict    (w_mispredict),
    .o_redirect_pc   (w_redirect_pc)
  );

  assign w_eligible = (r_state == S_COMMIT) && !rob_empty && head_ready &&
                      (head.ROB_number != 4'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_COMMIT;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Mealy outputs and next state; everything is forced low while reset is asserted.
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    rd_en          = 1'b0;
    rf_we          = 1'b0;
    rf_waddr       = '0;
    rf_wdata       = '0;
    rf_wrob        = '0;
    mem_req        = 1'b0;
    mem_addr       = '0;
    mem_wdata      = '0;
    flush          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    if (!reset) begin
      case (r_state)
        S_COMMIT: begin
          if (w_eligible) begin
            if (rob_head_store) begin
              mem_req     = 1'b1;
              mem_addr    = XLEN'(head.store_addr);
              mem_wdata   = XLEN'(head.value);
              w_state_nxt = S_ST_WAIT;
            end else if (head.itype == ITYPE_BRANCH) begin
              rd_en = 1'b1;
              if (w_mispredict) begin
                redirect_valid = 1'b1;
                redirect_pc    = w_redirect_pc;
                w_cnt_nxt      = CNT_W'(FLUSH_CYCLES);
                w_state_nxt    = S_FLUSH;
              end
            end else begin
              rd_en    = 1'b1;
              rf_we    = (head.dest_reg != 5'd0);
              rf_waddr = head.dest_reg;
              rf_wdata = XLEN'(head.value);
              rf_wrob  = head.ROB_number;
            end
          end
        end
        S_ST_WAIT: begin
          // Head is held by the ROB until we pop, so address/data stay stable.
          mem_req   = 1'b1;
          mem_addr  = XLEN'(head.store_addr);
          mem_wdata = XLEN'(head.value);
          if (mem_ack) begin
            rd_en       = !rob_empty;
            w_state_nxt = S_COMMIT;
          end
        end
        S_FLUSH: begin
          flush = 1'b1;
          if (r_cnt <= CNT_W'(1)) begin
            w_cnt_nxt   = '0;
            w_state_nxt = S_COMMIT;
          end else begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
          end
        end
        default: begin
          w_state_nxt = S_COMMIT;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

`ifdef COMMIT_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      retired_cnt    <= '0;
      mispredict_cnt <= '0;
    end else begin
      if (rd_en)          retired_cnt    <= retired_cnt + 32'd1;
      if (redirect_valid) mispredict_cnt <= mispredict_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_commit_unit.sv
// Self-checking bench for commit_unit: constant vector table, directed sequences, random vs. model.
module tb_commit_unit;
  import commit_unit_pkg::*;

  localparam int unsigned FLUSH_CYCLES = 2;

  logic        clk = 1'b0;
  logic        reset;
  ROB_entry_t  head;
  logic        head_ready, rob_empty, rob_head_store, mem_ack;
  logic        rd_en, rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [3:0]  rf_wrob;
  logic        mem_req;
  logic [31:0] mem_addr, mem_wdata;
  logic        flush, redirect_valid;
  logic [31:0] redirect_pc;
`ifdef COMMIT_PERF_CNT_EN
  logic [31:0] retired_cnt, mispredict_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  commit_unit #(.XLEN(32), .FLUSH_CYCLES(FLUSH_CYCLES)) dut (
    .clk(clk), .reset(reset), .head(head), .head_ready(head_ready),
    .rob_empty(rob_empty), .rob_head_store(rob_head_store),
    .rd_en(rd_en), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .rf_wrob(rf_wrob), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
`ifdef COMMIT_PERF_CNT_EN
    , .retired_cnt(retired_cnt), .mispredict_cnt(mispredict_cnt)
`endif
  );

  typedef struct packed {
    logic        rd_en;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [3:0]  rf_wrob;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
  } outs_t;

  // Reference model: pending store flag, remaining flush cycles, event counts.
  bit          m_store_wait = 1'b0;
  int          m_flush_left = 0;
  logic [31:0] m_retired = '0;
  logic [31:0] m_mispred = '0;

  function automatic outs_t actual();
    outs_t a;
    a = '{rd_en, rf_we, rf_waddr, rf_wdata, rf_wrob, mem_req, mem_addr,
          mem_wdata, flush, redirect_valid, redirect_pc};
    return a;
  endfunction

  task automatic chk_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Expected outputs for the current cycle, then advance the model one clock.
  task automatic model_cycle(output outs_t e);
    e = '0;
    if (reset) begin
      m_store_wait = 1'b0;
      m_flush_left = 0;
    end else if (m_flush_left > 0) begin
      e.flush = 1'b1;
      m_flush_left--;
    end else if (m_store_wait) begin
      e.mem_req   = 1'b1;
      e.mem_addr  = head.store_addr;
      e.mem_wdata = head.value;
      if (mem_ack) begin
        e.rd_en      = 1'b1;
        m_store_wait = 1'b0;
      end
    end else if (!rob_empty && head_ready && head.ROB_number != 0) begin
      if (rob_head_store) begin
        e.mem_req    = 1'b1;
        e.mem_addr   = head.store_addr;
        e.mem_wdata  = head.value;
        m_store_wait = 1'b1;
      end else if (head.itype == ITYPE_BRANCH) begin
        e.rd_en = 1'b1;
        if (head.branch_result != head.pred_taken) begin
          e.redirect_valid = 1'b1;
          e.redirect_pc    = head.branch_result ? head.branch_target : head.pc + 32'd4;
          m_flush_left     = FLUSH_CYCLES;
        end
      end else begin
        e.rd_en    = 1'b1;
        e.rf_we    = (head.dest_reg != 0);
        e.rf_waddr = head.dest_reg;
        e.rf_wdata = head.value;
        e.rf_wrob  = head.ROB_number;
      end
    end
  endtask

  // At the falling edge: compare DUT to model and advance the model.
  task automatic tick_check(input string name);
    outs_t e, a;
    @(negedge clk);
`ifdef COMMIT_PERF_CNT_EN
    chk_val({name, ".retired_cnt"}, retired_cnt, m_retired);
    chk_val({name, ".mispredict_cnt"}, mispredict_cnt, m_mispred);
`endif
    model_cycle(e);
    a = actual();
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, a, e);
    end
    if (reset) begin
      m_retired = '0;
      m_mispred = '0;
    end else begin
      if (e.rd_en)          m_retired = m_retired + 32'd1;
      if (e.redirect_valid) m_mispred = m_mispred + 32'd1;
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic set_head(input logic [1:0] it, input logic [3:0] tag, input logic [4:0] dst,
                          input logic [31:0] val, input logic [31:0] sa, input logic [31:0] pc,
                          input logic [31:0] tgt, input logic br, input logic pt);
    head = '{1'b1, it, tag, dst, val, sa, pc, tgt, br, pt};
    rob_head_store = (it == ITYPE_STORE);
  endtask

  typedef struct {
    string       name;
    logic        empty;
    logic        ready;
    logic [1:0]  it;
    logic [3:0]  tag;
    logic [4:0]  dst;
    logic [31:0] val;
    logic        br;
    logic        pt;
    logic        x_rd_en;
    logic        x_rf_we;
    logic [4:0]  x_waddr;
    logic [31:0] x_wdata;
    logic [3:0]  x_wrob;
  } vec_t;

  vec_t vecs[8];
  int   rd_cnt;

  initial begin
    vecs[0] = '{"alu",        0, 1, ITYPE_ALU,    3, 5,  32'hDEADBEEF, 0, 0, 1, 1, 5,  32'hDEADBEEF, 3};
    vecs[1] = '{"alu_b2b",    0, 1, ITYPE_ALU,    4, 31, 32'h12345678, 0, 0, 1, 1, 31, 32'h12345678, 4};
    vecs[2] = '{"load",       0, 1, ITYPE_LOAD,   15, 1, 32'h0000A5A5, 0, 0, 1, 1, 1,  32'h0000A5A5, 15};
    vecs[3] = '{"rob_empty",  1, 1, ITYPE_ALU,    3, 5,  32'h11111111, 0, 0, 0, 0, 0,  32'h0, 0};
    vecs[4] = '{"tag0",       0, 1, ITYPE_ALU,    0, 5,  32'h22222222, 0, 0, 0, 0, 0,  32'h0, 0};
    vecs[5] = '{"not_ready",  0, 0, ITYPE_LOAD,   6, 7,  32'h33333333, 0, 0, 0, 0, 0,  32'h0, 0};
    vecs[6] = '{"dest0",      0, 1, ITYPE_ALU,    7, 0,  32'h44444444, 0, 0, 1, 0, 0,  32'h44444444, 7};
    vecs[7] = '{"br_correct", 0, 1, ITYPE_BRANCH, 8, 0,  32'h0,        1, 1, 1, 0, 0,  32'h0, 0};

    reset = 1'b1; head = '0; head_ready = 1'b0; rob_empty = 1'b1;
    rob_head_store = 1'b0; mem_ack = 1'b0;
    adv();
    tick_check("reset"); adv();
    reset = 1'b0;
    tick_check("post_reset_idle"); adv();

    // Single-cycle vectors from the COMMIT state; none of them changes state.
    for (int i = 0; i < 8; i++) begin
      set_head(vecs[i].it, vecs[i].tag, vecs[i].dst, vecs[i].val, 32'h0, 32'h0, 32'h0,
               vecs[i].br, vecs[i].pt);
      rob_empty = vecs[i].empty; head_ready = vecs[i].ready;
      @(negedge clk);
      chk_val({vecs[i].name, ".rd_en"},  32'(rd_en),  32'(vecs[i].x_rd_en));
      chk_val({vecs[i].name, ".rf_we"},  32'(rf_we),  32'(vecs[i].x_rf_we));
      chk_val({vecs[i].name, ".waddr"},  32'(rf_waddr), 32'(vecs[i].x_waddr));
      chk_val({vecs[i].name, ".wdata"},  rf_wdata, vecs[i].x_wdata);
      chk_val({vecs[i].name, ".wrob"},   32'(rf_wrob), 32'(vecs[i].x_wrob));
      chk_val({vecs[i].name, ".redir"},  32'(redirect_valid), 32'h0);
      chk_val({vecs[i].name, ".flush"},  32'(flush), 32'h0);
      if (vecs[i].x_rd_en) m_retired = m_retired + 32'd1;
      adv();
    end

    // Store with ack after three wait cycles: mem_req for four cycles, one pop.
    set_head(ITYPE_STORE, 4'd9, 5'd2, 32'h55, 32'h100, 32'h0, 32'h0, 0, 0);
    rob_empty = 1'b0; head_ready = 1'b1; mem_ack = 1'b1;
    rd_cnt = 0;
    for (int c = 0; c < 4; c++) begin
      tick_check("store_seq");
      chk_val("store.mem_req", 32'(mem_req), 32'h1);
      chk_val("store.mem_addr", mem_addr, 32'h100);
      chk_val("store.mem_wdata", mem_wdata, 32'h55);
      rd_cnt += int'(rd_en);
      adv();
      mem_ack = (c == 2);
    end
    chk_val("store.rd_en_only_at_ack", 32'(rd_cnt), 32'd1);
    mem_ack = 1'b0; head_ready = 1'b0;
    tick_check("store_done_idle"); adv();

    // Taken mispredict: redirect to target, flush two cycles, then retire.
    set_head(ITYPE_BRANCH, 4'd5, 5'd0, 32'h0, 32'h0, 32'h40, 32'h80, 1, 0);
    head_ready = 1'b1;
    tick_check("mp_taken");
    chk_val("mp_taken.redirect_pc", redirect_pc, 32'h80);
    chk_val("mp_taken.redirect_valid", 32'(redirect_valid), 32'h1);
    adv();
    set_head(ITYPE_ALU, 4'd6, 5'd3, 32'hCAFE, 32'h0, 32'h0, 32'h0, 0, 0);
    for (int c = 0; c < 2; c++) begin
      tick_check("mp_flush");
      chk_val("mp_flush.flush", 32'(flush), 32'h1);
      chk_val("mp_flush.rd_en", 32'(rd_en), 32'h0);
      adv();
    end
    tick_check("mp_after_flush");
    chk_val("mp_after_flush.rd_en", 32'(rd_en), 32'h1);
    chk_val("mp_after_flush.flush", 32'(flush), 32'h0);
    adv();

    // Not-taken mispredict at the top of the address space wraps to zero.
    set_head(ITYPE_BRANCH, 4'd7, 5'd0, 32'h0, 32'h0, 32'hFFFFFFFC, 32'h1000, 0, 1);
    tick_check("mp_wrap");
    chk_val("mp_wrap.redirect_pc", redirect_pc, 32'h0);
    adv();
    head_ready = 1'b0;
    tick_check("wrap_flush0"); adv();
    tick_check("wrap_flush1"); adv();

    // Reset during ST_WAIT aborts the store; a late ack is then ignored.
    set_head(ITYPE_STORE, 4'd10, 5'd0, 32'h77, 32'h200, 32'h0, 32'h0, 0, 0);
    head_ready = 1'b1;
    tick_check("rst_store_issue"); adv();
    reset = 1'b1;
    tick_check("rst_in_wait");
    chk_val("rst_in_wait.mem_req", 32'(mem_req), 32'h0);
    adv();
    reset = 1'b0; head_ready = 1'b0; mem_ack = 1'b1;
    tick_check("late_ack_ignored");
    chk_val("late_ack.rd_en", 32'(rd_en), 32'h0);
    adv();
    head_ready = 1'b1;
    tick_check("same_cycle_ack_ignored");
    chk_val("same_cycle_ack.rd_en", 32'(rd_en), 32'h0);
    adv();
    tick_check("ack_in_wait"); adv();
    mem_ack = 1'b0;

    // Random traffic against the model; the head is held stable while a store waits.
    for (int n = 0; n < 600; n++) begin
      if (!m_store_wait) begin
        head.ready         = 1'b1;
        head.itype         = 2'($urandom_range(0, 3));
        head.ROB_number    = 4'($urandom_range(0, 15));
        head.dest_reg      = 5'($urandom_range(0, 31));
        head.value         = $urandom;
        head.store_addr    = $urandom;
        head.pc            = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFC : $urandom;
        head.branch_target = $urandom;
        head.branch_result = 1'($urandom_range(0, 1));
        head.pred_taken    = 1'($urandom_range(0, 1));
        rob_head_store     = (head.itype == ITYPE_STORE);
        rob_empty          = ($urandom_range(0, 7) == 0);
        head_ready         = ($urandom_range(0, 3) != 0);
      end
      mem_ack = ($urandom_range(0, 2) == 0);
      reset   = ($urandom_range(0, 99) == 0);
      tick_check("random");
      adv();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/commit_unit.md
Name: commit_unit

Overview:
- In-order retirement stage. Consumes the ROB head entry and dequeues it with a one-cycle pop strobe.
- Writes results to the architectural register file, performs stores to data memory through a req/ack handshake, and resolves branch mispredictions with a flush and PC redirect.
- Sits between the reorder buffer, register file/rename table, data memory port and fetch unit.

Parameters:
- XLEN, 32, data/address width.
- FLUSH_CYCLES, 2, number of cycles flush is held after a mispredict (≥1).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- head  in  ROB_entry_t  ROB head entry, combinational from ROB
- head_ready  in  1  head entry result valid
- rob_empty  in  1  ROB holds no entries
- rob_head_store  in  1  head is a store (itype 01)
- rd_en  out  1  pop ROB head this cycle
- rf_we  out  1  architectural register write
- rf_waddr  out  5  destination register
- rf_wdata  out  XLEN  write data
- rf_wrob  out  4  ROB tag retiring; rename table clears matching tag
- mem_req  out  1  store request
- mem_addr  out  XLEN  store address
- mem_wdata  out  XLEN  store data
- mem_ack  in  1  memory accepted store
- flush  out  1  squash ROB, RS and pipeline
- redirect_valid  out  1  one-cycle fetch redirect
- redirect_pc  out  XLEN  corrected fetch PC

Behaviour:
- Reset is synchronous, active-high, on clk. All outputs are 0 in and immediately after reset. State is COMMIT and the flush counter is 0.
- Outputs are Mealy (combinational from state + head). Only the FSM state, flush counter and optional counters are registered.
- Commit-eligible: state==COMMIT && !rob_empty && head_ready && head.ROB_number!=0. Tag 0 is reserved/invalid and never commits.
- itype encoding: 00 branch, 01 store, 10 ALU, 11 load.
- FSM states: COMMIT, ST_WAIT, FLUSH.
- COMMIT, ALU/load eligible:
  - rd_en=1, rf_we=1, rf_waddr=head.dest_reg, rf_wdata=head.value, rf_wrob=head.ROB_number.
  - If dest_reg==0: rf_we=0 but rd_en=1.
  - Stay in COMMIT. Throughput is one retire per cycle.
- COMMIT, store eligible (rob_head_store=1):
  - mem_req=1, mem_addr=head.store_addr, mem_wdata=head.value, rd_en=0.
  - Go to ST_WAIT.
  - A same-cycle mem_ack is ignored; the earliest ack counts in ST_WAIT.
- ST_WAIT:
  - Hold mem_req=1 with address and data from head (head is stable because no pop occurs).
  - On mem_ack: rd_en=1 the same cycle, go to COMMIT.
  - No timeout.
- COMMIT, branch eligible:
  - rd_en=1 always.
  - If head.branch_result==head.pred_taken: no further action, stay in COMMIT.
  - Else mispredict: redirect_valid=1 for this cycle. redirect_pc = branch_result ? head.branch_target : head.pc+4 (mod 2^XLEN). Go to FLUSH and load counter=FLUSH_CYCLES.
- FLUSH:
  - flush=1 and rd_en=0. Counter decrements each cycle.
  - When counter reaches 1, go to COMMIT on the next edge.
  - flush is therefore high exactly FLUSH_CYCLES cycles, starting the cycle after redirect_valid.
- Not eligible (empty, not ready, tag 0): all strobes are 0 and state holds.
- mem_ack outside ST_WAIT is ignored.
- Reset mid-ST_WAIT or mid-FLUSH: abort immediately. Go to COMMIT, mem_req=0, flush=0. No retire occurs.
- rd_en is never asserted while rob_empty=1.

Optional Feature:
- Macro COMMIT_PERF_CNT_EN.
- When defined, add outputs retired_cnt[31:0] and mispredict_cnt[31:0].
  - retired_cnt increments on every rd_en.
  - mispredict_cnt increments on every redirect_valid.
  - Both clear on reset and wrap modulo 2^32.
- When undefined, these ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package (structs.svh):
  - ROB_entry_t fields: ready, itype[1:0], ROB_number[3:0], dest_reg[4:0], value, store_addr, pc, branch_target, branch_result, pred_taken.
  - itype localparams ITYPE_BRANCH/STORE/ALU/LOAD.
  - commit_state_t enum.
- Sub-module: commit_branch_resolve. Combinational mispredict detect and redirect_pc computation, reused later by early-branch recovery.

Test Plan:
- ALU retire: head{itype=10, ROB_number=3, dest_reg=5, value=0xDEADBEEF, ready}, rob_empty=0 -> same cycle rd_en=1, rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF, rf_wrob=3. Back-to-back ready heads retire every cycle.
- Store handshake: head{itype=01, store_addr=0x100, value=0x55}, ack after 3 cycles -> mem_req held 4 cycles with stable address/data, rd_en=1 only in the ack cycle.
- Mispredict: branch pc=0x40, pred_taken=0, branch_result=1, target=0x80, FLUSH_CYCLES=2 -> rd_en=1, redirect_valid=1, redirect_pc=0x80. flush=1 next 2 cycles with no retires; then an ALU head retires.
- Not-taken mispredict at pc=0xFFFFFFFC, pred_taken=1 -> redirect_pc=0x00000000 (wrap).
- Ineligible heads: rob_empty=1 with head_ready=1; ROB_number=0 with ready; dest_reg=0 ALU -> no rd_en for the first two; for the third rd_en=1 with rf_we=0.
- Reset in ST_WAIT: assert reset during mem_req -> next cycle mem_req=0, state COMMIT. A late mem_ack is ignored. With COMMIT_PERF_CNT_EN, counters read 0.
